ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
Registered execute-stage operand stage for the RV32 pipeline. It latches one ID/EX instruction and selects ALU operands s1 (rs1 or PC) and s2 (rs2 or immediate). Each register operand is resolved through a priority bypass network with NUM_FWD sources, including late load data from the D-cache. It holds the instruction while any needed bypass data is still pending, and presents operands to the ALU over a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
NUM_FWD, 3, number of bypass sources; index 0 = youngest, highest priority
RAW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash held instruction (branch mispredict / trap)
in_valid  in  1  ID/EX instruction valid
in_ready  out  1  stage can accept an instruction
in_sel1  in  1  1 = s1 from rs1, 0 = s1 from PC
in_sel2  in  1  1 = s2 from rs2, 0 = s2 from immediate
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  decoded immediate
in_rs1_addr / in_rs2_addr  in  RAW each  source register addresses
in_rs1_data / in_rs2_data  in  XLEN each  register-file read data
fwd_valid  in  NUM_FWD  bypass source carries a register write
fwd_pending  in  NUM_FWD  write target known but data not yet available (load in flight)
fwd_addr  in  NUM_FWD*RAW  bypass destination addresses, packed
fwd_data  in  NUM_FWD*XLEN  bypass data, packed
out_valid  out  1  operands valid
out_ready  in  1  ALU consumes operands
out_s1 / out_s2  out  XLEN each  selected ALU operands
out_rs2  out  XLEN  resolved rs2 value, used as store data regardless of in_sel2

Behaviour:
- Reset (async, rst_n=0): state EMPTY; out_valid=0; out_s1, out_s2, out_rs2 = 0; all holding registers = 0.
- States:
  - EMPTY: no instruction held.
  - WAIT: instruction held, at least one operand unresolved.
  - FULL: both operands resolved, out_valid=1.
- in_ready = (state==EMPTY) || (state==FULL && out_ready). It is never asserted in WAIT.
- Accept = in_valid && in_ready. On accept, latch pc, imm, sel1, sel2, both addresses and both register-file values.
- Operand resolution, per operand, on the same cycle as accept or any later cycle:
  - Find the lowest index i with fwd_valid[i] and fwd_addr[i]==addr, and addr!=0.
  - Match with fwd_pending[i]=1: operand stays unresolved.
  - Match with fwd_pending[i]=0: value = fwd_data[i], resolved.
  - No match: value = held register-file data, resolved.
- Address x0 always resolves to 0.
- An operand not used by its select (sel1=0 or sel2=0) still resolves rs2 for out_rs2. It never blocks on rs1 when sel1=0. rs2 always blocks, because store data is needed.
- Once an operand resolves, its value is frozen in the holding register. Later bypass changes are ignored.
- Transitions:
  - EMPTY, accept: FULL if both operands resolve that cycle, else WAIT.
  - WAIT: FULL on the cycle the last operand resolves.
  - FULL with out_ready and no accept: EMPTY.
  - FULL with out_ready and accept: FULL or WAIT for the new instruction (back-to-back, no bubble).
  - FULL with out_ready=0: hold all outputs stable.
- Latency: operands registered, so out_valid is asserted 1 cycle after accept when no operand is pending. Each pending cycle adds 1.
- Outputs: out_s1 = sel1 ? rs1 : pc; out_s2 = sel2 ? rs2 : imm. Both are driven from registers, with no combinational path from fwd_* to out_*.
- flush has priority over everything: next state EMPTY, out_valid=0, and any same-cycle accept is discarded. A flush in WAIT drops the stalled instruction.
- Multiple bypass sources matching the same address: the lowest index wins.

Optional Feature:
FWD_STALL_CNT_EN
- Defined: adds output port stall_cnt (32 bit). It increments on every cycle spent in WAIT and saturates at 0xFFFFFFFF. It is cleared only by rst_n.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package ex_pkg holds:
  - constants XLEN_DEF=32, RAW_DEF=5, NUM_FWD_DEF=3;
  - state enum {EMPTY, WAIT, FULL};
  - operand select encodings SEL_RS=1, SEL_PC=0, SEL_IMM=0.
- Sub-module fwd_resolve: combinational priority match of one address against the bypass buses. It outputs hit, pending and data, and is instantiated once per operand.

Test Plan:
- No hazards: in_sel1=1, in_sel2=0, rs1=x5 (RF 0x10), imm 0x4 -> next cycle out_valid=1, out_s1=0x10, out_s2=0x4.
- Priority: fwd[0] and fwd[2] both write x7 with 0xAA and 0xBB, rs1=x7 -> out_s1=0xAA. With rs1=x0 and a bypass to x0 -> out_s1=0.
- Load-use stall: fwd[1] addr x9 pending for 3 cycles, rs2=x9, in_sel2=1 -> in_ready=0 and WAIT for 3 cycles. When pending drops with data 0x1234 -> out_s2=0x1234, out_rs2=0x1234. With FWD_STALL_CNT_EN, stall_cnt=3.
- Backpressure and back-to-back: out_ready=0 for 2 cycles -> outputs held stable. Then out_ready=1 with in_valid=1 -> new instruction accepted same cycle, no bubble.
- Flush: flush asserted in WAIT and again with in_valid=1 in EMPTY -> state EMPTY, out_valid=0, nothing accepted.
- Reset mid-WAIT: rst_n low asynchronously -> out_valid=0 and all outputs 0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the execute-stage operand logic.
//   XLEN_DEF / RAW_DEF / NUM_FWD_DEF : default datapath, register-address
//                                      and bypass-source counts
//   state_e                          : operand stage occupancy states
//   SEL_*                            : operand select encodings
package ex_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RAW_DEF     = 5;
  localparam int NUM_FWD_DEF = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic SEL_RS  = 1'b1;
  localparam logic SEL_PC  = 1'b0;
  localparam logic SEL_IMM = 1'b0;

endpackage

// File: rtl/ex_operand_stage_fwd_resolve.sv
// fwd_resolve: combinational priority match of one source register address
// against the packed bypass buses. Index 0 is the youngest source and wins.
//   addr        : source register address (x0 never matches)
//   fwd_valid   : per-source write valid
//   fwd_pending : per-source "data not yet available"
//   fwd_addr    : packed destination addresses
//   fwd_data    : packed write data
//   hit         : some valid source targets addr
//   pending     : the winning source has no data yet
//   data        : winning source's data (0 when no hit)
module fwd_resolve
  import ex_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RAW     = RAW_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input  logic [RAW-1:0]          addr,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*RAW-1:0]  fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    hit,
  output logic                    pending,
  output logic [XLEN-1:0]         data
);

  // Scan oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    hit     = 1'b0;
    pending = 1'b0;
    data    = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if ((addr != '0) && fwd_valid[i] && (fwd_addr[i*RAW +: RAW] == addr)) begin
        hit     = 1'b1;
        pending = fwd_pending[i];
        data    = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: registered ID/EX operand stage. Latches one instruction,
// resolves rs1/rs2 through the bypass network (waiting on in-flight loads),
// and presents s1/s2/store data to the ALU over valid/ready.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : squash held instruction, drop same-cycle accept
//   in_valid / in_ready   : ID/EX handshake
//   in_sel1 / in_sel2     : 1 = register operand, 0 = PC / immediate
//   in_pc, in_imm         : instruction PC and immediate
//   in_rs*_addr/_data     : source addresses and register-file read data
//   fwd_valid/_pending/_addr/_data : bypass sources, index 0 youngest
//   out_valid / out_ready : ALU handshake
//   out_s1, out_s2        : selected ALU operands
//   out_rs2               : resolved rs2 (store data)
// Optional build macro FWD_STALL_CNT_EN adds stall_cnt, a saturating count
// of cycles spent in WAIT, cleared only by reset.
//
// state | meaning
// EMPTY | no instruction held
// WAIT  | instruction held, an operand still waits on bypass data
// FULL  | both operands resolved, out_valid = 1
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int RAW     = RAW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sel1,
  input  logic                    in_sel2,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [RAW-1:0]          in_rs1_addr,
  input  logic [RAW-1:0]          in_rs2_addr,
  input  logic [XLEN-1:0]         in_rs1_data,
  input  logic [XLEN-1:0]         in_rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*RAW-1:0]  fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_s1,
  output logic [XLEN-1:0]         out_s2,
  output logic [XLEN-1:0]         out_rs2
`ifdef FWD_STALL_CNT_EN
  ,output logic [31:0]            stall_cnt
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [RAW-1:0]  a1_q, a1_d, a2_q, a2_d;
  logic            sel1_q, sel1_d, sel2_q, sel2_d;
  logic            ok1_q, ok1_d, ok2_q, ok2_d;
  logic [XLEN-1:0] s1_q, s1_d, s2_q, s2_d, rs2o_q, rs2o_d;

  logic            accept;
  logic [RAW-1:0]  a1_cur, a2_cur;
  logic            hit1, pend1, hit2, pend2;
  logic [XLEN-1:0] data1, data2;

  assign in_ready = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Resolution looks at the incoming addresses on the accept cycle, so a
  // hazard-free instruction goes straight to FULL.
  assign a1_cur = accept ? in_rs1_addr : a1_q;
  assign a2_cur = accept ? in_rs2_addr : a2_q;

  fwd_resolve #(.XLEN(XLEN), .RAW(RAW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .addr(a1_cur), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .hit(hit1), .pending(pend1), .data(data1)
  );

  fwd_resolve #(.XLEN(XLEN), .RAW(RAW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .addr(a2_cur), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .hit(hit2), .pending(pend2), .data(data2)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    ok1_d   = ok1_q;
    ok2_d   = ok2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rs2o_d  = rs2o_q;

    if (accept) begin
      pc_d   = in_pc;
      imm_d  = in_imm;
      sel1_d = in_sel1;
      sel2_d = in_sel2;
      a1_d   = in_rs1_addr;
      a2_d   = in_rs2_addr;
      rs1_d  = in_rs1_data;
      rs2_d  = in_rs2_data;
      ok1_d  = 1'b0;
      ok2_d  = 1'b0;
    end

    // rsN_d holds register-file data until resolved, then the frozen value.
    if (accept || (state_q == WAIT)) begin
      if (!ok1_d) begin
        if (a1_cur == '0) begin
          rs1_d = '0;
          ok1_d = 1'b1;
        end else if (hit1 && pend1) begin
          // rs1 is only waited on when it actually feeds s1
          ok1_d = (sel1_d != SEL_RS);
        end else begin
          if (hit1) rs1_d = data1;
          ok1_d = 1'b1;
        end
      end
      if (!ok2_d) begin
        if (a2_cur == '0) begin
          rs2_d = '0;
          ok2_d = 1'b1;
        end else if (!(hit2 && pend2)) begin
          if (hit2) rs2_d = data2;
          ok2_d = 1'b1;
        end
      end
    end

    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = (ok1_d && ok2_d) ? FULL : WAIT;
    end else if ((state_q == WAIT) && ok1_d && ok2_d) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end

    // Output registers only load when a new instruction becomes FULL, so a
    // stalled FULL (out_ready=0) keeps them stable.
    if (!flush && (state_d == FULL) && (accept || (state_q == WAIT))) begin
      s1_d   = (sel1_d == SEL_RS) ? rs1_d : pc_d;
      s2_d   = (sel2_d == SEL_RS) ? rs2_d : imm_d;
      rs2o_d = rs2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      sel1_q  <= 1'b0;
      sel2_q  <= 1'b0;
      ok1_q   <= 1'b0;
      ok2_q   <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      rs2o_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      ok1_q   <= ok1_d;
      ok2_q   <= ok2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rs2o_q  <= rs2o_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_s1    = s1_q;
  assign out_s2    = s2_q;
  assign out_rs2   = rs2o_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == WAIT) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios followed by randomized traffic,
// checked against an instruction-level reference model of the operand stage.
// Build with FWD_STALL_CNT_EN defined to also check stall_cnt.
module tb_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int NF   = 3;
  localparam int RAW  = 5;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_sel1, in_sel2, out_ready;
  logic              in_ready, out_valid;
  logic [XLEN-1:0]   in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [RAW-1:0]    in_rs1_addr, in_rs2_addr;
  logic [NF-1:0]     fwd_valid, fwd_pending;
  logic [RAW-1:0]    fa [NF];
  logic [XLEN-1:0]   fd [NF];
  logic [NF*RAW-1:0] fwd_addr;
  logic [NF*XLEN-1:0] fwd_data;
  logic [XLEN-1:0]   out_s1, out_s2, out_rs2;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  assign fwd_addr = {fa[2], fa[1], fa[0]};
  assign fwd_data = {fd[2], fd[1], fd[0]};

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel1(in_sel1), .in_sel2(in_sel2),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s1(out_s1), .out_s2(out_s2), .out_rs2(out_rs2)
`ifdef FWD_STALL_CNT_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the held instruction and what is known of its operands.
  bit          m_held, m_have1, m_have2, m_use1, m_use2;
  logic [31:0] m_pc, m_imm, m_v1, m_v2;
  logic [4:0]  m_a1, m_a2;
  logic [31:0] m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest bypass writing the register, as (found, waiting, value).
  function automatic void youngest_writer(input logic [4:0] a, output bit found,
                                          output bit waiting, output logic [31:0] v);
    found = 0; waiting = 0; v = '0;
    if (a != 5'd0)
      for (int i = 0; i < NF; i++)
        if (!found && fwd_valid[i] && fa[i] == a) begin
          found = 1; waiting = fwd_pending[i]; v = fd[i];
        end
  endfunction

  task automatic learn_operands();
    bit f, w; logic [31:0] v;
    if (!m_have1) begin
      youngest_writer(m_a1, f, w, v);
      if (m_a1 == 5'd0) begin m_v1 = 0; m_have1 = 1; end
      else if (!(f && w)) begin if (f) m_v1 = v; m_have1 = 1; end
      else if (!m_use1) m_have1 = 1;
    end
    if (!m_have2) begin
      youngest_writer(m_a2, f, w, v);
      if (m_a2 == 5'd0) begin m_v2 = 0; m_have2 = 1; end
      else if (!(f && w)) begin if (f) m_v2 = v; m_have2 = 1; end
    end
  endtask

  // Inputs are already driven (just after a posedge); check, advance model,
  // clock, then check the registered outputs.
  task automatic step();
    bit ready_now, acc, done;
    #1;
    done = m_held && m_have1 && m_have2;
    ready_now = !m_held || (done && out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, ready_now});
    if (m_held && !done && m_stall != 32'hFFFF_FFFF) m_stall++;
    acc = in_valid && ready_now && !flush;
    if (flush) m_held = 0;
    else if (acc) begin
      m_held = 1; m_have1 = 0; m_have2 = 0;
      m_pc = in_pc; m_imm = in_imm; m_use1 = in_sel1; m_use2 = in_sel2;
      m_a1 = in_rs1_addr; m_a2 = in_rs2_addr; m_v1 = in_rs1_data; m_v2 = in_rs2_data;
      learn_operands();
    end else if (done && out_ready) m_held = 0;
    else if (m_held) learn_operands();
    @(posedge clk); #1;
    done = m_held && m_have1 && m_have2;
    chk("out_valid", {31'd0, out_valid}, {31'd0, done});
    if (done) begin
      chk("out_s1", out_s1, m_use1 ? m_v1 : m_pc);
      chk("out_s2", out_s2, m_use2 ? m_v2 : m_imm);
      chk("out_rs2", out_rs2, m_v2);
    end
`ifdef FWD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_sel1 = 1; in_sel2 = 1;
    in_pc = 0; in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; fwd_valid = 0; fwd_pending = 0;
    for (int i = 0; i < NF; i++) begin fa[i] = 0; fd[i] = 0; end
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 19) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    in_sel1 = $urandom_range(0, 1); in_sel2 = $urandom_range(0, 1);
    in_pc = $urandom; in_imm = $urandom;
    in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
    in_rs1_data = $urandom; in_rs2_data = $urandom;
    fwd_valid = 3'($urandom); fwd_pending = 3'($urandom & $urandom);
    for (int i = 0; i < NF; i++) begin fa[i] = 5'($urandom_range(0, 3)); fd[i] = $urandom; end
  endtask

  initial begin
    logic [31:0] stall0;
    m_held = 0; m_have1 = 0; m_have2 = 0; m_use1 = 0; m_use2 = 0;
    m_pc = 0; m_imm = 0; m_v1 = 0; m_v2 = 0; m_a1 = 0; m_a2 = 0; m_stall = 0;
    idle(); out_ready = 1; rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_s1", out_s1, 32'd0);
    chk("rst_out_s2", out_s2, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1;

    // No hazards: s1 = rs1 from RF, s2 = immediate
    in_valid = 1; in_sel1 = 1; in_sel2 = 0; in_rs1_addr = 5; in_rs1_data = 32'h10;
    in_imm = 32'h4; in_pc = 32'h100;
    step();
    chk("nohaz_s1", out_s1, 32'h10);
    chk("nohaz_s2", out_s2, 32'h4);

    // Priority: fwd[0] beats fwd[2] on x7 (back-to-back accept from FULL)
    in_rs1_addr = 7; in_rs1_data = 32'h1; fwd_valid = 3'b101;
    fa[0] = 7; fd[0] = 32'hAA; fa[2] = 7; fd[2] = 32'hBB;
    step();
    chk("prio_s1", out_s1, 32'hAA);
    // x0 ignores a bypass that targets it
    in_rs1_addr = 0; in_rs1_data = 32'h99; fwd_valid = 3'b001; fa[0] = 0; fd[0] = 32'h55;
    step();
    chk("x0_s1", out_s1, 32'h0);
    idle(); step();

    // Load-use: fwd[1] pending on x9 for three cycles
    stall0 = m_stall;
    in_valid = 1; in_sel1 = 0; in_sel2 = 1; in_rs2_addr = 9; in_rs2_data = 32'hDEAD;
    in_pc = 32'h200; fwd_valid = 3'b010; fwd_pending = 3'b010; fa[1] = 9; fd[1] = 32'h1;
    step(); step(); step();
    chk("lu_stalled", {31'd0, out_valid}, 32'd0);
    fwd_pending = 0; fd[1] = 32'h1234;
    step();
    chk("lu_s2", out_s2, 32'h1234);
    chk("lu_rs2", out_rs2, 32'h1234);
    chk("lu_stall_cycles", m_stall - stall0, 32'd3);

    // Backpressure then back-to-back accept
    idle(); out_ready = 0;
    step(); step();
    chk("bp_hold_s2", out_s2, 32'h1234);
    out_ready = 1; in_valid = 1; in_sel1 = 1; in_rs1_addr = 5; in_rs1_data = 32'h77;
    step();
    chk("b2b_s1", out_s1, 32'h77);

    // Flush in WAIT, then flush with in_valid from EMPTY
    idle(); in_valid = 1; in_rs2_addr = 3; fwd_valid = 3'b001; fwd_pending = 3'b001; fa[0] = 3;
    step(); step();
    in_valid = 0; flush = 1;
    step();
    in_valid = 1; fwd_valid = 0; fwd_pending = 0;
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    idle(); step();

    // Reset asserted mid-WAIT
    in_valid = 1; in_rs1_addr = 1; in_rs1_data = 32'h42; in_sel1 = 1; in_rs2_addr = 0;
    step();
    in_rs2_addr = 2; fwd_valid = 3'b100; fwd_pending = 3'b100; fa[2] = 2;
    step();
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("rstw_valid", {31'd0, out_valid}, 32'd0);
    chk("rstw_s1", out_s1, 32'd0);
    chk("rstw_rs2", out_rs2, 32'd0);
    m_held = 0; m_stall = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("rstw_in_ready", {31'd0, in_ready}, 32'd1);
    idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
